// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals for the shared memory port.
// The arbiter uses the slave modport; requesters and memory use the master modport.
interface mem_port_arbiter_if;
    logic        req0;
    logic [31:0] addr0;
    logic        req1;
    logic [31:0] addr1;
    logic        wr1;
    logic [31:0] wdata1;
    logic [31:0] mem_rdata;
    logic        mem_en;
    logic        mem_wr;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_sel;
    logic        gnt0;
    logic        gnt1;
    logic        done0;
    logic        done1;
    logic [31:0] rdata;
    logic        busy;

    modport slave (
        input  req0, addr0, req1, addr1, wr1, wdata1, mem_rdata,
        output mem_en, mem_wr, mem_addr, mem_wdata, mem_sel,
               gnt0, gnt1, done0, done1, rdata, busy
    );

    modport master (
        output req0, addr0, req1, addr1, wr1, wdata1, mem_rdata,
        input  mem_en, mem_wr, mem_addr, mem_wdata, mem_sel,
               gnt0, gnt1, done0, done1, rdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (0)
// and data load/store (1); every output is registered.
module mem_port_arbiter #(
    parameter int LATENCY = 2,
    parameter int CNT_W   = 4
) (
    input  logic               clock,
    input  logic               reset,
    mem_port_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LATENCY - 1);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              last_owner_q, last_owner_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_wr_q, mem_wr_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              mem_sel_q, mem_sel_d;
    logic              gnt0_q, gnt0_d;
    logic              gnt1_q, gnt1_d;
    logic              done0_q, done0_d;
    logic              done1_q, done1_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              busy_q, busy_d;
    logic              winner;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        owner_d      = owner_q;
        last_owner_d = last_owner_q;
        mem_en_d     = mem_en_q;
        mem_wr_d     = mem_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        mem_sel_d    = mem_sel_q;
        rdata_d      = rdata_q;
        gnt0_d       = 1'b0;
        gnt1_d       = 1'b0;
        done0_d      = 1'b0;
        done1_d      = 1'b0;
        winner       = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.req0 || bus.req1) begin
                    // On contention the requester that did not own the port last time wins.
                    winner      = (bus.req0 && bus.req1) ? ~last_owner_q : bus.req1;
                    owner_d     = winner;
                    mem_sel_d   = winner;
                    mem_addr_d  = winner ? bus.addr1 : bus.addr0;
                    mem_wr_d    = winner & bus.wr1;
                    mem_wdata_d = winner ? bus.wdata1 : 32'h0;
                    cnt_d       = CNT_LOAD;
                    gnt0_d      = ~winner;
                    gnt1_d      = winner;
                    mem_en_d    = 1'b1;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    if (!mem_wr_q) begin
                        rdata_d = bus.mem_rdata;
                    end
                    done0_d      = ~owner_q;
                    done1_d      = owner_q;
                    mem_en_d     = 1'b0;
                    mem_wr_d     = 1'b0;
                    last_owner_d = owner_q;
                    state_d      = RESP;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            owner_q      <= 1'b0;
            last_owner_q <= 1'b1;
            mem_en_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= 32'h0;
            mem_wdata_q  <= 32'h0;
            mem_sel_q    <= 1'b0;
            gnt0_q       <= 1'b0;
            gnt1_q       <= 1'b0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
            rdata_q      <= 32'h0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            owner_q      <= owner_d;
            last_owner_q <= last_owner_d;
            mem_en_q     <= mem_en_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            mem_sel_q    <= mem_sel_d;
            gnt0_q       <= gnt0_d;
            gnt1_q       <= gnt1_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_sel   = mem_sel_q;
    assign bus.gnt0      = gnt0_q;
    assign bus.gnt1      = gnt1_q;
    assign bus.done0     = done0_q;
    assign bus.done1     = done1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus randomized traffic checked
// against a transaction-timing model (LATENCY=2 instance and a LATENCY=1 instance).
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    mem_port_arbiter_if bus0();
    mem_port_arbiter_if bus1();

    mem_port_arbiter #(.LATENCY(LAT), .CNT_W(4)) u_dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus0)
    );

    mem_port_arbiter #(.LATENCY(1), .CNT_W(4)) u_dut_l1 (
        .clock (clock),
        .reset (reset),
        .bus   (bus1)
    );

    task automatic clear_inputs();
        bus0.req0 = 0; bus0.addr0 = 0; bus0.req1 = 0; bus0.addr1 = 0;
        bus0.wr1 = 0; bus0.wdata1 = 0; bus0.mem_rdata = 0;
        bus1.req0 = 0; bus1.addr0 = 0; bus1.req1 = 0; bus1.addr1 = 0;
        bus1.wr1 = 0; bus1.wdata1 = 0; bus1.mem_rdata = 0;
    endtask

    // Leaves the bench at a falling edge with reset released; next rising edge is edge 1.
    task automatic do_reset();
        clear_inputs();
        reset = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1;
    endtask

    task automatic test_reset();
        logic [7:0] v;
        clear_inputs();
        reset = 0;
        @(posedge clock); #1;
        v = {bus0.mem_en, bus0.mem_wr, bus0.mem_sel, bus0.gnt0, bus0.gnt1, bus0.done0, bus0.done1, bus0.busy};
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl: got %b expected 00000000", v); end
        checks++;
        if (bus0.rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 00000000", bus0.rdata); end
        checks++;
        if ({bus0.mem_addr, bus0.mem_wdata} !== 64'h0) begin
            errors++; $display("FAIL reset_addr_wdata: got %h/%h expected 0/0", bus0.mem_addr, bus0.mem_wdata);
        end
        v = {bus1.mem_en, bus1.mem_wr, bus1.mem_sel, bus1.gnt0, bus1.gnt1, bus1.done0, bus1.done1, bus1.busy};
        checks++;
        if (v !== 8'h00) begin errors++; $display("FAIL reset_ctrl_l1: got %b expected 00000000", v); end
        $display("reset: outputs sampled in reset");
    endtask

    task automatic test_single_read();
        logic [5:0] v, exp;
        do_reset();
        bus0.req0 = 1; bus0.addr0 = 32'h4; bus0.mem_rdata = 32'hDEADBEEF;
        for (int e = 1; e <= 4; e++) begin
            @(posedge clock); #1;
            v   = {bus0.gnt0, bus0.gnt1, bus0.mem_en, bus0.mem_sel, bus0.done0, bus0.busy};
            exp = {e == 1, 1'b0, e <= 2, 1'b0, e == 3, e <= 3};
            checks++;
            if (v !== exp) begin errors++; $display("FAIL read_ctrl edge%0d: got %b expected %b", e, v, exp); end
            if (e <= 2) begin
                checks++;
                if (bus0.mem_addr !== 32'h4) begin errors++; $display("FAIL read_addr edge%0d: got %h expected 00000004", e, bus0.mem_addr); end
            end
            if (e >= 3) begin
                checks++;
                if (bus0.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL read_rdata edge%0d: got %h expected deadbeef", e, bus0.rdata); end
                bus0.req0 = 0;
            end
        end
        $display("single_read: addr=00000004 rdata=%h", bus0.rdata);
    endtask

    // Runs straight after test_single_read with the arbiter idle.
    task automatic test_write();
        logic [5:0] v, exp;
        bus0.req1 = 1; bus0.wr1 = 1; bus0.addr1 = 32'h100; bus0.wdata1 = 32'h12345678;
        bus0.mem_rdata = 32'hBAD0BAD0;
        for (int j = 0; j < 4; j++) begin
            @(posedge clock); #1;
            v   = {bus0.gnt1, bus0.mem_en, bus0.mem_wr, bus0.mem_sel, bus0.done1, bus0.done0};
            exp = {j == 0, j <= 1, j <= 1, 1'b1, j == 2, 1'b0};
            checks++;
            if (v !== exp) begin errors++; $display("FAIL write_ctrl cyc%0d: got %b expected %b", j, v, exp); end
            if (j <= 1) begin
                checks++;
                if ({bus0.mem_addr, bus0.mem_wdata} !== {32'h100, 32'h12345678}) begin
                    errors++; $display("FAIL write_bus cyc%0d: got %h/%h expected 00000100/12345678", j, bus0.mem_addr, bus0.mem_wdata);
                end
            end
            checks++;
            if (bus0.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL write_rdata cyc%0d: got %h expected deadbeef", j, bus0.rdata); end
            if (j == 2) bus0.req1 = 0;
        end
        $display("write: addr=00000100 wdata=12345678 rdata kept %h", bus0.rdata);
    endtask

    task automatic test_contention();
        logic [3:0] v, exp;
        int ph, who;
        do_reset();
        bus0.req0 = 1; bus0.req1 = 1; bus0.addr0 = 32'hA0; bus0.addr1 = 32'hB0;
        for (int e = 1; e <= 16; e++) begin
            @(posedge clock); #1;
            ph  = (e - 1) % (LAT + 2);
            who = ((e - 1) / (LAT + 2)) % 2;
            exp = {ph == 0 && who == 0, ph == 0 && who == 1, ph == LAT && who == 0, ph == LAT && who == 1};
            v   = {bus0.gnt0, bus0.gnt1, bus0.done0, bus0.done1};
            checks++;
            if (v !== exp) begin errors++; $display("FAIL contention edge%0d: got %b expected %b", e, v, exp); end
            if (ph == 0) $display("contention: edge %0d grant to requester %0d", e, who);
        end
    endtask

    task automatic test_latched();
        do_reset();
        bus0.req0 = 1; bus0.addr0 = 32'h4; bus0.mem_rdata = 32'h0BADF00D;
        @(posedge clock); #1;
        checks++;
        if (bus0.gnt0 !== 1'b1) begin errors++; $display("FAIL latch_gnt: got %b expected 1", bus0.gnt0); end
        bus0.addr0 = 32'hFFFFFFFC; bus0.req0 = 0;
        @(posedge clock); #1;
        checks++;
        if (bus0.mem_addr !== 32'h4) begin errors++; $display("FAIL latch_addr: got %h expected 00000004", bus0.mem_addr); end
        @(posedge clock); #1;
        checks++;
        if ({bus0.done0, bus0.rdata} !== {1'b1, 32'h0BADF00D}) begin
            errors++; $display("FAIL latch_done: got %b/%h expected 1/0badf00d", bus0.done0, bus0.rdata);
        end
        $display("latched: mem_addr held after addr change and req drop");
    endtask

    task automatic test_reset_mid();
        logic [7:0] v;
        do_reset();
        bus0.req0 = 1; bus0.addr0 = 32'h40;
        repeat (2) @(posedge clock);
        #1 reset = 0;
        #1;
        v = {bus0.mem_en, bus0.mem_wr, bus0.mem_sel, bus0.gnt0, bus0.gnt1, bus0.done0, bus0.done1, bus0.busy};
        checks++;
        if (v !== 8'h00 || bus0.mem_addr !== 32'h0) begin
            errors++; $display("FAIL midreset_outputs: got %b/%h expected 00000000/0", v, bus0.mem_addr);
        end
        @(posedge clock); #1;
        checks++;
        if ({bus0.done0, bus0.done1} !== 2'b00) begin errors++; $display("FAIL midreset_done: got %b expected 00", {bus0.done0, bus0.done1}); end
        @(negedge clock);
        bus0.req0 = 1; bus0.req1 = 1;
        reset = 1;
        @(posedge clock); #1;
        checks++;
        if ({bus0.gnt0, bus0.gnt1} !== 2'b10) begin errors++; $display("FAIL midreset_regrant: got %b expected 10", {bus0.gnt0, bus0.gnt1}); end
        $display("reset_mid: abandoned transaction, fetch regranted first");
    endtask

    task automatic test_latency1();
        logic [3:0] v, exp;
        do_reset();
        bus1.req0 = 1; bus1.addr0 = 32'h8; bus1.mem_rdata = 32'hCAFEF00D;
        for (int e = 1; e <= 3; e++) begin
            @(posedge clock); #1;
            v   = {bus1.gnt0, bus1.mem_en, bus1.done0, bus1.busy};
            exp = {e == 1, e == 1, e == 2, e <= 2};
            checks++;
            if (v !== exp) begin errors++; $display("FAIL lat1_ctrl edge%0d: got %b expected %b", e, v, exp); end
            if (e == 2) begin
                checks++;
                if (bus1.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL lat1_rdata: got %h expected cafef00d", bus1.rdata); end
                bus1.req0 = 0;
            end
        end
        $display("latency1: rdata=%h", bus1.rdata);
    endtask

    // Model: a grant at edge g makes the port active over [g, g+LAT-1], done at g+LAT,
    // busy over [g, g+LAT], and the next decision at g+LAT+2.
    task automatic test_random();
        int grant_e = -100, done_e = -100, next_free = 1, ntx = 0;
        logic last_owner = 1'b1, owner = 1'b0, exp_sel = 1'b0, lat_wr = 1'b0, active;
        logic [31:0] lat_addr = 0, lat_wdata = 0, exp_rdata = 0;
        logic [7:0] v, exp;
        do_reset();
        for (int e = 1; e <= 800; e++) begin
            if (!bus0.req0 && $urandom_range(0, 2) == 0) bus0.req0 = 1;
            if (!bus0.req1 && $urandom_range(0, 2) == 0) bus0.req1 = 1;
            if ($urandom_range(0, 1) == 1) bus0.addr0 = $urandom;
            if ($urandom_range(0, 1) == 1) begin
                bus0.addr1 = $urandom; bus0.wdata1 = $urandom; bus0.wr1 = 1'($urandom_range(0, 1));
            end
            bus0.mem_rdata = $urandom;
            if (e >= next_free && (bus0.req0 || bus0.req1)) begin
                owner      = (bus0.req0 && bus0.req1) ? ~last_owner : bus0.req1;
                last_owner = owner;
                exp_sel    = owner;
                lat_addr   = owner ? bus0.addr1 : bus0.addr0;
                lat_wr     = owner & bus0.wr1;
                lat_wdata  = owner ? bus0.wdata1 : 32'h0;
                grant_e    = e;
                done_e     = e + LAT;
                next_free  = e + LAT + 2;
            end
            if (e == done_e && !lat_wr) exp_rdata = bus0.mem_rdata;
            @(posedge clock); #1;
            active = (e >= grant_e) && (e < done_e);
            exp = {e == grant_e && !owner, e == grant_e && owner, e == done_e && !owner, e == done_e && owner,
                   active, active && lat_wr, e >= grant_e && e <= done_e, exp_sel};
            v   = {bus0.gnt0, bus0.gnt1, bus0.done0, bus0.done1, bus0.mem_en, bus0.mem_wr, bus0.busy, bus0.mem_sel};
            checks++;
            if (v !== exp) begin errors++; $display("FAIL rand_ctrl edge%0d: got %b expected %b", e, v, exp); end
            checks++;
            if (bus0.rdata !== exp_rdata) begin errors++; $display("FAIL rand_rdata edge%0d: got %h expected %h", e, bus0.rdata, exp_rdata); end
            if (active) begin
                checks++;
                if ({bus0.mem_addr, bus0.mem_wdata} !== {lat_addr, lat_wdata}) begin
                    errors++; $display("FAIL rand_bus edge%0d: got %h/%h expected %h/%h", e, bus0.mem_addr, bus0.mem_wdata, lat_addr, lat_wdata);
                end
            end
            if (e == done_e) begin
                ntx++;
                $display("rand txn %0d: owner=%0d wr=%0b addr=%h rdata=%h", ntx, owner, lat_wr, lat_addr, exp_rdata);
                if (owner) bus0.req1 = 0; else bus0.req0 = 0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_write();
        test_contention();
        test_latched();
        test_reset_mid();
        test_latency1();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
